// File: rtl/fetch_pc_unit.sv
// Stage-1 PC generator and instruction fetch sequencer: one outstanding imem request,
// a one-entry skid behind the decode output register, redirect squash and misalignment trap.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush_o,
    output logic        exc_misalign,
    output logic [31:0] exc_addr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        halt_pending;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        out_free;
    logic        misaligned;
    logic        owed;
    logic        take_rsp;
    logic        grant;

    // imem_req depends only on registered state and redirect_valid, never on rdata/rvalid.
    always_comb begin
        out_free   = !if_valid || !if_stall;
        misaligned = redirect_pc[1:0] != 2'b00;
        owed       = (state == S_WAIT || state == S_DISCARD) && !imem_rvalid;
        take_rsp   = (state == S_WAIT) && imem_rvalid && !redirect_valid;
        imem_req   = n_rst && (state == S_FETCH) && !skid_valid && !redirect_valid;
        imem_addr  = {pc[31:2], 2'b00};
        grant      = imem_req && imem_gnt;
        flush_o    = redirect_valid;
        dbg_state  = state;

        state_next = state;
        if (redirect_valid) begin
            if (owed)            state_next = S_DISCARD;
            else if (misaligned) state_next = S_HALT;
            else                 state_next = S_FETCH;
        end else begin
            case (state)
                S_FETCH:   if (grant) state_next = S_WAIT;
                S_WAIT:    if (imem_rvalid) state_next = S_FETCH;
                S_DISCARD: if (imem_rvalid) state_next = halt_pending ? S_HALT : S_FETCH;
                default:   state_next = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= S_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pc           <= RESET_PC;
            req_pc       <= 32'd0;
            halt_pending <= 1'b0;
            if_valid     <= 1'b0;
            if_instr     <= 32'd0;
            if_pc        <= 32'd0;
            skid_valid   <= 1'b0;
            skid_instr   <= 32'd0;
            skid_pc      <= 32'd0;
            exc_misalign <= 1'b0;
            exc_addr     <= 32'd0;
        end else if (redirect_valid) begin
            pc           <= redirect_pc;
            if_valid     <= 1'b0;
            skid_valid   <= 1'b0;
            // Remembered so a pending DISCARD knows whether to resume or halt.
            halt_pending <= misaligned;
            if (misaligned) begin
                exc_misalign <= 1'b1;
                exc_addr     <= redirect_pc;
            end else begin
                exc_misalign <= 1'b0;
            end
        end else begin
            if (grant) begin
                req_pc <= pc;
                pc     <= pc + PC_INC;
            end
            if (out_free) begin
                if (skid_valid) begin
                    if_valid   <= 1'b1;
                    if_instr   <= skid_instr;
                    if_pc      <= skid_pc;
                    skid_valid <= 1'b0;
                end else if (take_rsp) begin
                    if_valid <= 1'b1;
                    if_instr <= imem_rdata;
                    if_pc    <= req_pc;
                end else begin
                    if_valid <= 1'b0;
                end
            end else if (take_rsp) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: per-cycle vector table, directed corner sequences, and a
// randomized run against a transaction-level fetch model with an expected queue.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush_o;
    logic        exc_misalign;
    logic [31:0] exc_addr;
    logic [1:0]  dbg_state;

    int compared = 0;
    int mismatched = 0;

    // Each entry is {pc, instr} of a granted fetch not yet taken by decode.
    logic [63:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        gnt;
        logic        rv;
        logic [31:0] rda;
        logic        er;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] eipc;
        logic        eexc;
        logic [31:0] eexca;
    } vec_t;

    vec_t tbl[21];

    fetch_pc_unit dut (
        .clk(clk), .n_rst(n_rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_stall(if_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush_o(flush_o), .exc_misalign(exc_misalign), .exc_addr(exc_addr),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic reset_dut();
        repeat (3) begin
            @(negedge clk);
            n_rst = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc = 32'd0;
            if_stall = 1'b0;
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata = 32'd0;
        end
    endtask

    // Memory image: instruction word stored at each address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic rst, input logic redir, input logic [31:0] rpc,
                                 input logic stall, input logic gnt, input logic rv,
                                 input logic [31:0] rda, input logic er, input logic [31:0] ea,
                                 input logic eiv, input logic [31:0] eipc,
                                 input logic eexc, input logic [31:0] eexca);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.stall = stall; v.gnt = gnt;
        v.rv = rv; v.rda = rda; v.er = er; v.ea = ea; v.eiv = eiv; v.eipc = eipc;
        v.eexc = eexc; v.eexca = eexca;
        return v;
    endfunction

    // driver: inputs at negedge, outputs checked 1ns later (before the next posedge)
    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        n_rst = v.rst;
        redirect_valid = v.redir;
        redirect_pc = v.rpc;
        if_stall = v.stall;
        imem_gnt = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata = word_of(v.rda);
        #1;
        chk({tag, ".req"}, imem_req, v.er);
        if (v.er) chk({tag, ".addr"}, imem_addr, v.ea);
        chk({tag, ".if_valid"}, if_valid, v.eiv);
        if (v.eiv) begin
            chk({tag, ".if_pc"}, if_pc, v.eipc);
            chk({tag, ".if_instr"}, if_instr, word_of(v.eipc));
        end
        chk({tag, ".flush"}, flush_o, v.redir);
        chk({tag, ".exc"}, exc_misalign, v.eexc);
        if (v.eexc) chk({tag, ".exc_addr"}, exc_addr, v.eexca);
    endtask

    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                        input logic stall, input logic gnt, input logic rv,
                        input logic [31:0] rda, input logic er, input logic [31:0] ea,
                        input logic eiv, input logic [31:0] eipc,
                        input logic eexc, input logic [31:0] eexca, input string tag);
        apply_vec(mkv(rst, redir, rpc, stall, gnt, rv, rda, er, ea, eiv, eipc, eexc, eexca), tag);
    endtask

    // Randomized run: the model tracks the architectural fetch stream, not the FSM.
    task automatic run_random(input int n);
        logic [31:0] m_pc = 32'd0;
        logic [31:0] m_exc_addr = 32'd0;
        logic        m_exc = 1'b0;
        logic        m_halt = 1'b0;
        logic        mem_pend = 1'b0;
        int          mem_wait = 0;
        logic [31:0] mem_addr = 32'd0;
        int          consumed = 0;
        logic [31:0] rpc;
        logic [31:0] tmp;
        logic [63:0] front;
        int          k;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_rst = 1'b1;
            k = $urandom_range(0, 9);
            tmp = $urandom_range(0, 1023);
            rpc = {22'd0, tmp[9:0]};
            if (k == 0) begin
                if (rpc[1:0] == 2'b00) rpc[0] = 1'b1;
            end else if (k == 1) begin
                rpc = 32'hFFFF_FFF8;
            end else begin
                rpc[1:0] = 2'b00;
            end
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = rpc;
            if_stall = ($urandom_range(0, 2) == 0);
            imem_gnt = ($urandom_range(0, 3) != 0);
            imem_rvalid = mem_pend && (mem_wait == 0);
            imem_rdata = imem_rvalid ? word_of(mem_addr) : $urandom();
            #1;
            chk("rnd.exc", exc_misalign, m_exc);
            if (m_exc) chk("rnd.exc_addr", exc_addr, m_exc_addr);
            chk("rnd.flush", flush_o, redirect_valid);
            if (imem_req) chk("rnd.req_allowed", mem_pend || m_halt || redirect_valid, 1'b0);
            if (if_valid) begin
                chk("rnd.queue_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    front = exp_q[0];
                    chk("rnd.if_pc", if_pc, front[63:32]);
                    chk("rnd.if_instr", if_instr, front[31:0]);
                    if (!if_stall) begin
                        void'(exp_q.pop_front());
                        consumed++;
                    end
                end
            end
            if (imem_rvalid) mem_pend = 1'b0;
            else if (mem_pend) mem_wait--;
            if (imem_req && imem_gnt) begin
                chk("rnd.addr", imem_addr, m_pc);
                exp_q.push_back({m_pc, word_of(m_pc)});
                m_pc = m_pc + 32'd4;
                mem_pend = 1'b1;
                mem_wait = $urandom_range(0, 2);
                mem_addr = imem_addr;
            end
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = rpc;
                m_exc = (rpc[1:0] != 2'b00);
                m_halt = m_exc;
                if (m_exc) m_exc_addr = rpc;
            end
        end
        chk("rnd.throughput", consumed >= 100, 1'b1);
    endtask

    initial begin
        // reset release, steady fetch, then a 6-cycle stall filling the skid
        tbl[0]  = mkv(0,0,0,0,1,0,0,      0,0,      0,0,     0,0);
        tbl[1]  = mkv(1,0,0,0,1,0,0,      1,0,      0,0,     0,0);
        tbl[2]  = mkv(1,0,0,0,1,1,0,      0,0,      0,0,     0,0);
        tbl[3]  = mkv(1,0,0,0,1,0,0,      1,4,      1,0,     0,0);
        tbl[4]  = mkv(1,0,0,0,1,1,4,      0,0,      0,0,     0,0);
        tbl[5]  = mkv(1,0,0,0,1,0,0,      1,8,      1,4,     0,0);
        tbl[6]  = mkv(1,0,0,0,1,1,8,      0,0,      0,0,     0,0);
        tbl[7]  = mkv(1,0,0,0,1,0,0,      1,'hC,    1,8,     0,0);
        tbl[8]  = mkv(1,0,0,0,1,1,'hC,    0,0,      0,0,     0,0);
        tbl[9]  = mkv(1,0,0,0,1,0,0,      1,'h10,   1,'hC,   0,0);
        tbl[10] = mkv(1,0,0,0,1,1,'h10,   0,0,      0,0,     0,0);
        tbl[11] = mkv(1,0,0,1,1,0,0,      1,'h14,   1,'h10,  0,0);
        tbl[12] = mkv(1,0,0,1,1,1,'h14,   0,0,      1,'h10,  0,0);
        tbl[13] = mkv(1,0,0,1,1,0,0,      0,0,      1,'h10,  0,0);
        tbl[14] = mkv(1,0,0,1,1,0,0,      0,0,      1,'h10,  0,0);
        tbl[15] = mkv(1,0,0,1,1,0,0,      0,0,      1,'h10,  0,0);
        tbl[16] = mkv(1,0,0,1,1,0,0,      0,0,      1,'h10,  0,0);
        tbl[17] = mkv(1,0,0,0,1,0,0,      0,0,      1,'h10,  0,0);
        tbl[18] = mkv(1,0,0,0,1,0,0,      1,'h18,   1,'h14,  0,0);
        tbl[19] = mkv(1,0,0,0,1,1,'h18,   0,0,      0,0,     0,0);
        tbl[20] = mkv(1,0,0,0,1,0,0,      1,'h1C,   1,'h18,  0,0);

        reset_dut();
        for (int i = 0; i < 21; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // redirect while waiting: stale word dropped via DISCARD
        reset_dut();
        step(1,0,0,0,1,0,0,        1,0,       0,0,      0,0, "t3_f0");
        step(1,0,0,0,1,1,0,        0,0,       0,0,      0,0, "t3_r0");
        step(1,0,0,0,1,0,0,        1,4,       1,0,      0,0, "t3_f4");
        step(1,0,0,0,1,1,4,        0,0,       0,0,      0,0, "t3_r4");
        step(1,0,0,0,1,0,0,        1,8,       1,4,      0,0, "t3_f8");
        step(1,1,'h200,0,1,0,0,    0,0,       0,0,      0,0, "t3_redir");
        step(1,0,0,0,1,0,0,        0,0,       0,0,      0,0, "t3_disc");
        step(1,0,0,0,1,1,8,        0,0,       0,0,      0,0, "t3_stale");
        step(1,0,0,0,1,0,0,        1,'h200,   0,0,      0,0, "t3_f200");
        step(1,0,0,0,1,1,'h200,    0,0,       0,0,      0,0, "t3_r200");
        step(1,0,0,0,1,0,0,        1,'h204,   1,'h200,  0,0, "t3_f204");

        // redirect with same-cycle rvalid
        step(1,1,'h100,0,1,1,'h204, 0,0,      0,0,      0,0, "t4_redir");
        step(1,0,0,0,1,0,0,        1,'h100,   0,0,      0,0, "t4_f100");
        step(1,0,0,0,1,1,'h100,    0,0,       0,0,      0,0, "t4_r100");
        step(1,0,0,0,0,0,0,        1,'h104,   1,'h100,  0,0, "t4_nognt");
        step(1,0,0,0,1,0,0,        1,'h104,   0,0,      0,0, "t4_f104");
        step(1,0,0,0,1,1,'h104,    0,0,       0,0,      0,0, "t4_r104");

        // misaligned redirect from FETCH, then from WAIT (DISCARD then HALT)
        step(1,1,'h102,0,1,0,0,    0,0,       1,'h104,  0,0, "t5_mis");
        for (int i = 0; i < 3; i++)
            step(1,0,0,0,1,0,0,    0,0,       0,0,      1,'h102, "t5_halt");
        step(1,1,'h80,0,1,0,0,     0,0,       0,0,      1,'h102, "t5_redir_ok");
        step(1,0,0,0,1,0,0,        1,'h80,    0,0,      0,0, "t5_f80");
        step(1,0,0,0,1,1,'h80,     0,0,       0,0,      0,0, "t5_r80");
        step(1,0,0,0,1,0,0,        1,'h84,    1,'h80,   0,0, "t5_f84");
        step(1,1,'h333,0,1,0,0,    0,0,       0,0,      0,0, "t5_mis_wait");
        step(1,0,0,0,1,1,'h84,     0,0,       0,0,      1,'h333, "t5_disc");
        step(1,0,0,0,1,0,0,        0,0,       0,0,      1,'h333, "t5_halt2");
        step(1,1,'hFFFF_FFFC,0,1,0,0, 0,0,    0,0,      1,'h333, "t5_redir_top");

        // PC wrap and reset in the middle of WAIT
        step(1,0,0,0,1,0,0,        1,'hFFFF_FFFC, 0,0,  0,0, "t6_ftop");
        step(1,0,0,0,1,1,'hFFFF_FFFC, 0,0,    0,0,      0,0, "t6_rtop");
        step(1,0,0,0,0,0,0,        1,0,       1,'hFFFF_FFFC, 0,0, "t6_wrap");
        step(1,0,0,0,1,0,0,        1,0,       0,0,      0,0, "t6_f0");
        step(0,0,0,0,0,0,0,        0,0,       0,0,      0,0, "t6_rst_wait");
        step(0,0,0,0,1,0,0,        0,0,       0,0,      0,0, "t6_rst_gate");
        step(1,0,0,0,0,1,0,        1,0,       0,0,      0,0, "t6_late_rv");
        step(1,0,0,0,0,0,0,        1,0,       0,0,      0,0, "t6_after");

        reset_dut();
        run_random(2000);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
